cpu_run_controller: RTL and testbench

- Run/debug sequencer for the 4-bit CPU (PC, A/B/OUT registers, ROM, decoder).
- Loads the 16x8 program memory from a valid/ready byte stream.
- Clears the CPU state, then gates CPU progress with a clock-enable.
- Supports run, single-step, stop, PC breakpoint, self-jump halt detection and cycle timeout, and reports the halt cause and cycles executed.

---
 rtl/cpu_run_controller_pkg.sv | 24 ++
 rtl/cpu_run_controller_cycle_counter.sv | 38 +++
 rtl/cpu_run_controller.sv | 167 ++++++++++++++++
 tb/tb_cpu_run_controller.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_run_controller_pkg.sv
// Shared definitions for the CPU run/debug sequencer.
//   run_state_e  : sequencer state encodings (visible on the STATE port)
//   halt_cause_e : reason codes reported on HALT_CAUSE
//   DEFAULT_HALT_OP : unconditional-jump opcode used for self-jump detection
package cpu_run_controller_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_STEP  = 3'd3,
    S_HALT  = 3'd4
  } run_state_e;

  typedef enum logic [1:0] {
    CAUSE_STOP    = 2'd0,
    CAUSE_SELFJMP = 2'd1,
    CAUSE_BRK     = 2'd2,
    CAUSE_TIMEOUT = 2'd3
  } halt_cause_e;

  localparam logic [3:0] DEFAULT_HALT_OP = 4'b1011;

endpackage

// File: rtl/cpu_run_controller_cycle_counter.sv
// Saturating executed-cycle counter.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset (count -> 0)
//   clr   : synchronous clear (count -> 0), wins over en
//   en    : count one cycle; holds at all-ones instead of wrapping
//   count : current count
module cpu_cycle_counter #(
  parameter int unsigned CYC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CYC_W-1:0] count
);

  logic [CYC_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/cpu_run_controller.sv
// Run/debug sequencer for the 4-bit CPU.
// Loads the 16x8 program memory from a valid/ready byte stream, clears the
// CPU, then gates CPU progress with CPU_CE. Supports run, single-step, stop,
// PC breakpoint, self-jump halt and cycle timeout.
//   CK, RST                : clock (rising), synchronous active-high reset
//   START/STEP/STOP        : clear+run pulse, single-step pulse, halt level
//   LD_VALID/LD_DATA/LD_READY : program byte stream
//   MEM_WE/MEM_AD/MEM_D    : program memory write port
//   PC/OP/IM               : current CPU program counter and instruction
//   BRK_EN/BRK_AD          : breakpoint
//   CPU_CE/CPU_CLR         : CPU clock enable and synchronous clear
//   STATE/HALT_CAUSE/CYCLES/DONE : status
module cpu_run_controller
  import cpu_run_controller_pkg::*;
#(
  parameter int unsigned      CYC_W      = 16,
  parameter logic [CYC_W-1:0] MAX_CYCLES = 16'hFFFF,
  parameter logic [3:0]       HALT_OP    = DEFAULT_HALT_OP
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             START,
  input  logic             STEP,
  input  logic             STOP,
  input  logic             LD_VALID,
  input  logic [7:0]       LD_DATA,
  output logic             LD_READY,
  output logic             MEM_WE,
  output logic [3:0]       MEM_AD,
  output logic [7:0]       MEM_D,
  input  logic [3:0]       PC,
  input  logic [3:0]       OP,
  input  logic [3:0]       IM,
  input  logic             BRK_EN,
  input  logic [3:0]       BRK_AD,
  output logic             CPU_CE,
  output logic             CPU_CLR,
  output logic [2:0]       STATE,
  output logic [1:0]       HALT_CAUSE,
  output logic [CYC_W-1:0] CYCLES,
  output logic             DONE
);

  run_state_e  state_q, state_d;
  halt_cause_e cause_q, cause_d;
  halt_cause_e halt_sel;
  logic [3:0]  ptr_q, ptr_d;
  logic        wr_pend_q, wr_pend_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        done_q, done_d;
  logic        ld_ok, accept, halt_any;
  logic        cnt_clr, cnt_en;
  logic        cpu_ce, cpu_clr;
  logic [CYC_W-1:0] cycles;

  cpu_cycle_counter #(.CYC_W(CYC_W)) u_cycle_counter (
    .clk   (CK),
    .rst   (RST),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (cycles)
  );

  // Halt conditions in priority order; the first match sets the cause.
  always_comb begin
    halt_any = 1'b1;
    halt_sel = CAUSE_STOP;
    if (STOP) begin
      halt_sel = CAUSE_STOP;
    end else if ((OP == HALT_OP) && (IM == PC)) begin
      halt_sel = CAUSE_SELFJMP;
    end else if (BRK_EN && (PC == BRK_AD)) begin
      halt_sel = CAUSE_BRK;
    end else if (cycles == MAX_CYCLES) begin
      halt_sel = CAUSE_TIMEOUT;
    end else begin
      halt_any = 1'b0;
    end
  end

  // START takes priority over a byte offered in the same cycle, so ready
  // drops with START to keep the handshake honest.
  assign ld_ok  = ((state_q == S_IDLE) || (state_q == S_HALT)) && !START;
  assign accept = LD_VALID && ld_ok;

  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    done_d    = done_q;
    ptr_d     = wr_pend_q ? ptr_q + 4'd1 : ptr_q;
    wr_pend_d = accept;
    wr_data_d = accept ? LD_DATA : wr_data_q;
    cpu_ce    = 1'b0;
    cpu_clr   = 1'b0;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (START) begin
          state_d = S_CLEAR;
          ptr_d   = '0;
        end else if ((state_q == S_HALT) && STEP) begin
          state_d = S_STEP;
        end
      end
      S_CLEAR: begin
        cpu_clr = 1'b1;
        cnt_clr = 1'b1;
        done_d  = 1'b0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (START) begin
          state_d = S_CLEAR;
          ptr_d   = '0;
        end else if (halt_any) begin
          state_d = S_HALT;
          cause_d = halt_sel;
          done_d  = (halt_sel == CAUSE_SELFJMP);
        end else begin
          cpu_ce = 1'b1;
          cnt_en = 1'b1;
        end
      end
      S_STEP: begin
        cpu_ce  = 1'b1;
        cnt_en  = 1'b1;
        state_d = S_HALT;
      end
      default: state_d = S_IDLE;
    endcase
    if (RST) begin
      cpu_ce  = 1'b0;
      cpu_clr = 1'b1;
    end
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      cause_q   <= CAUSE_STOP;
      ptr_q     <= '0;
      wr_pend_q <= 1'b0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      ptr_q     <= ptr_d;
      wr_pend_q <= wr_pend_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
    end
  end

  assign LD_READY   = ld_ok;
  assign MEM_WE     = wr_pend_q;
  assign MEM_AD     = ptr_q;
  assign MEM_D      = wr_data_q;
  assign CPU_CE     = cpu_ce;
  assign CPU_CLR    = cpu_clr;
  assign STATE      = state_q;
  assign HALT_CAUSE = cause_q;
  assign CYCLES     = cycles;
  assign DONE       = done_q && (state_q == S_HALT);

endmodule

// File: tb/tb_cpu_run_controller.sv
module tb_cpu_run_controller;
  localparam int MAXC = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0, start = 1'b0, step = 1'b0, stop = 1'b0;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_data = '0;
  logic        ld_ready, mem_we, cpu_ce, cpu_clr, done;
  logic [3:0]  mem_ad, pc, op, im;
  logic [7:0]  mem_d;
  logic        brk_en = 1'b0;
  logic [3:0]  brk_ad = '0;
  logic [2:0]  state;
  logic [1:0]  halt_cause;
  logic [15:0] cycles;

  cpu_run_controller #(.CYC_W(16), .MAX_CYCLES(16'(MAXC)), .HALT_OP(4'b1011)) dut (
    .CK(clk), .RST(rst), .START(start), .STEP(step), .STOP(stop),
    .LD_VALID(ld_valid), .LD_DATA(ld_data), .LD_READY(ld_ready),
    .MEM_WE(mem_we), .MEM_AD(mem_ad), .MEM_D(mem_d),
    .PC(pc), .OP(op), .IM(im), .BRK_EN(brk_en), .BRK_AD(brk_ad),
    .CPU_CE(cpu_ce), .CPU_CLR(cpu_clr), .STATE(state),
    .HALT_CAUSE(halt_cause), .CYCLES(cycles), .DONE(done)
  );

  // Minimal CPU: program memory fed by the controller, PC advances by one
  // or jumps on opcode B.
  logic [7:0] cpu_mem [16];
  assign op = cpu_mem[pc][7:4];
  assign im = cpu_mem[pc][3:0];
  always @(posedge clk) begin
    if (mem_we) cpu_mem[mem_ad] <= mem_d;
    if (cpu_clr) pc <= '0;
    else if (cpu_ce) pc <= (op == 4'hB) ? im : pc + 4'd1;
  end

  int n_cmp = 0, n_bad = 0;
  int ce_cnt = 0, clr_cnt = 0, bad_we = 0;
  int wr_addr_q[$];
  int wr_data_q[$];
  logic [7:0] prog [16];

  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr_q.push_back(int'(mem_ad));
      wr_data_q.push_back(int'(mem_d));
      if (state inside {3'd1, 3'd2, 3'd3}) bad_we++;
    end
    if (cpu_ce) ce_cnt++;
    if (cpu_clr && !rst) clr_cnt++;
  end

  task automatic check(input string tag, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instruction-level reference: walk the program from address 0 and stop
  // at the first rule that fires before executing the current instruction.
  task automatic model_run(input bit ben, input logic [3:0] bad, input int stop_at,
                           output int cause, output int n, output logic [3:0] p);
    p = '0; n = 0; cause = -1;
    while (cause < 0) begin
      if (n == stop_at) cause = 0;
      else if (prog[p] == {4'hB, p}) cause = 1;
      else if (ben && p == bad) cause = 2;
      else if (n == MAXC) cause = 3;
      else begin
        p = (prog[p][7:4] == 4'hB) ? prog[p][3:0] : p + 4'd1;
        n++;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_clr", cpu_clr, 1);
    check("rst_ce", cpu_ce, 0);
    tick();
    rst = 1'b0;
    #1;
    check("rst_state", state, 0);
    check("rst_cycles", cycles, 0);
    check("rst_cause", halt_cause, 0);
    check("rst_done", done, 0);
    check("rst_ld_ready", ld_ready, 1);
  endtask

  task automatic load_prog(input int nb);
    wr_addr_q.delete();
    wr_data_q.delete();
    for (int i = 0; i < nb; i++) begin
      ld_valid = 1'b1;
      ld_data  = prog[i];
      #1;
      check("ld_ready", ld_ready, 1);
      tick();
    end
    ld_valid = 1'b0;
    tick();
    check("ld_nwr", wr_addr_q.size(), nb);
    for (int i = 0; i < nb && i < wr_addr_q.size(); i++) begin
      check("ld_ad", wr_addr_q[i], i % 16);
      check("ld_d", wr_data_q[i], prog[i]);
    end
  endtask

  task automatic run_test(input bit ben, input logic [3:0] bad, input int stop_at,
                          input bit do_step, input bit valid_in_run);
    int ecause, en, ce0, clr0;
    logic [3:0] epc, npc;
    bit halted;
    model_run(ben, bad, stop_at, ecause, en, epc);
    brk_en = ben;
    brk_ad = bad;
    ce0 = ce_cnt;
    clr0 = clr_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("clr_state", state, 1);
    check("clr_pulse", cpu_clr, 1);
    halted = 1'b0;
    for (int j = 0; j < 64; j++) begin
      tick();
      if (state == 3'd4) begin halted = 1'b1; break; end
      if (j == 0) begin
        ld_valid = valid_in_run;
        check("run_ld_ready", ld_ready, 0);
      end
      if (stop_at >= 0 && j >= stop_at) stop = 1'b1;
      #1;
      if (ecause == 0 && j == stop_at) check("stop_ce", cpu_ce, 0);
    end
    stop = 1'b0;
    ld_valid = 1'b0;
    check("halted", halted, 1);
    check("cause", halt_cause, ecause);
    check("cycles", cycles, en);
    check("halt_pc", pc, epc);
    check("done", done, ecause == 1);
    check("ce_count", ce_cnt - ce0, en);
    check("clr_count", clr_cnt - clr0, 1);
    if (do_step) begin
      npc = (prog[epc][7:4] == 4'hB) ? prog[epc][3:0] : epc + 4'd1;
      ce0 = ce_cnt;
      step = 1'b1;
      tick();
      step = 1'b0;
      check("step_state", state, 3);
      tick();
      check("step_halt", state, 4);
      check("step_cycles", cycles, en + 1);
      check("step_cause", halt_cause, ecause);
      check("step_ce", ce_cnt - ce0, 1);
      check("step_pc", pc, npc);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int ce0;
    tick();
    do_reset();

    // STEP in IDLE is ignored
    ce0 = ce_cnt;
    step = 1'b1; tick(); step = 1'b0; tick();
    check("idle_step_state", state, 0);
    check("idle_step_ce", ce_cnt - ce0, 0);

    // Load and run to self-jump
    foreach (prog[i]) prog[i] = 8'h00;
    prog[0] = 8'h4C; prog[1] = 8'hA0; prog[2] = 8'hAF; prog[3] = 8'h11;
    prog[4] = 8'hC1; prog[5] = 8'hA1; prog[6] = 8'hB6;
    load_prog(7);
    run_test(1'b0, 4'd0, -1, 1'b0, 1'b0);
    check("selfjmp_cycles", cycles, 6);

    // Breakpoint, then step past it; LD_VALID held during RUN is ignored
    wr_addr_q.delete();
    run_test(1'b1, 4'd3, -1, 1'b1, 1'b1);
    check("run_no_write", wr_addr_q.size(), 0);

    // STOP coinciding with breakpoint
    run_test(1'b1, 4'd2, 2, 1'b0, 1'b0);

    // Timeout
    foreach (prog[i]) prog[i] = 8'h00;
    load_prog(16);
    run_test(1'b0, 4'd0, -1, 1'b1, 1'b0);

    // Reset mid-run
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1; #1;
    check("midrun_rst_clr", cpu_clr, 1);
    tick(); rst = 1'b0; #1;
    check("midrun_state", state, 0);
    check("midrun_cycles", cycles, 0);

    // Reset mid-load, then a fresh load starts at address 0
    for (int i = 0; i < 16; i++) prog[i] = 8'($urandom);
    for (int i = 0; i < 3; i++) begin ld_valid = 1'b1; ld_data = prog[i]; tick(); end
    rst = 1'b1; #1;
    check("midload_rst_clr", cpu_clr, 1);
    tick(); rst = 1'b0; ld_valid = 1'b0; #1;
    check("midload_state", state, 0);
    check("midload_ld_ready", ld_ready, 1);
    load_prog(16);

    // Randomised programs, breakpoints and stop timing
    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < 16; i++) begin
        prog[i] = 8'($urandom);
        if ($urandom_range(0, 3) == 0) prog[i][7:4] = 4'hB;
      end
      load_prog(16);
      run_test(1'($urandom), 4'($urandom),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : -1,
               1'b1, 1'($urandom));
    end

    check("no_we_busy", bad_we, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
